// File: rtl/dmem_access_unit.sv
// dmem_access_unit -- CPU-side initiator for an 8-bit data memory port.
//
// Converts single/multi-beat load/store requests into one memory command
// per cycle with auto-incrementing (wrapping) addresses. Loads return a
// pipelined per-beat response stream; done pulses once per request.
//
// Optional feature (compile-time macro DMAU_READBACK_EN):
//   store bursts are buffered and read back afterwards; any byte that
//   differs from what was written sets the sticky err flag.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready   request handshake (ready only while IDLE)
//   req_write             1 = store burst, 0 = load burst
//   req_addr, req_len     first beat address, beats minus one
//   wr_data, wr_pop       show-ahead store data source and its pop strobe
//   cmd_out, addr_out     registered memory command (1 = write) and address
//   data                  bidirectional memory data bus
//   rsp_valid, rsp_data   per-beat load response (no backpressure)
//   busy, done, err       status: not idle, completion pulse, readback error
module dmem_access_unit #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int MAX_LEN_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [MAX_LEN_W-1:0] req_len,
  input  logic [DATA_W-1:0]    wr_data,
  output logic                 wr_pop,
  output logic                 cmd_out,
  output logic [ADDR_W-1:0]    addr_out,
  inout  wire  [DATA_W-1:0]    data,
  output logic                 rsp_valid,
  output logic [DATA_W-1:0]    rsp_data,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int CNT_W = MAX_LEN_W + 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD      = 3'd2,
    RD_TAIL = 3'd3
`ifdef DMAU_READBACK_EN
    , VERIFY      = 3'd4
    , VERIFY_TAIL = 3'd5
`endif
  } state_t;

  state_t               state, state_d;
  logic [CNT_W-1:0]     cnt;
  logic [MAX_LEN_W-1:0] len_q;
  logic [CNT_W-1:0]     last_cnt;
  logic                 more;
  logic                 data_oe;
  logic [DATA_W-1:0]    wdata_p0;
  logic                 rd_vld_p0;

  // cnt holds the number of beats issued so far, including the current one
  assign last_cnt = {1'b0, len_q} + CNT_W'(1);
  assign more     = (cnt != last_cnt);

  assign data = data_oe ? wdata_p0 : {DATA_W{1'bz}};

  always_comb begin
    state_d   = state;
    req_ready = 1'b0;
    wr_pop    = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy      = 1'b0;
        req_ready = 1'b1;
        if (req_valid) begin
          wr_pop  = req_write && !rst;
          state_d = req_write ? WR : RD;
        end
      end
      WR: begin
        if (more) begin
          wr_pop = !rst;
        end else begin
`ifdef DMAU_READBACK_EN
          state_d = VERIFY;
`else
          state_d = IDLE;
`endif
        end
      end
      RD:      if (!more) state_d = RD_TAIL;
      RD_TAIL: state_d = IDLE;
`ifdef DMAU_READBACK_EN
      VERIFY:      if (!more) state_d = VERIFY_TAIL;
      VERIFY_TAIL: state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

`ifdef DMAU_READBACK_EN
  logic [ADDR_W-1:0]    start_addr;
  logic [DATA_W-1:0]    wbuf [2**MAX_LEN_W];
  logic                 vfy_vld_p0;
  logic [MAX_LEN_W-1:0] vfy_idx_p0;
  logic                 err_q;

  assign err = err_q;

  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid) start_addr <= req_addr;
    if (state == WR) wbuf[MAX_LEN_W'(cnt - CNT_W'(1))] <= wdata_p0;
    vfy_idx_p0 <= MAX_LEN_W'(cnt - CNT_W'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vfy_vld_p0 <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      vfy_vld_p0 <= (state == VERIFY);
      if (state == IDLE && req_valid) begin
        err_q <= 1'b0;
      end else if (vfy_vld_p0 && (data != wbuf[vfy_idx_p0])) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  assign err = 1'b0;
`endif

  // store data stage: loaded whenever the source is popped
  always_ff @(posedge clk) begin
    if (wr_pop) wdata_p0 <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cmd_out   <= 1'b0;
      addr_out  <= '0;
      data_oe   <= 1'b0;
      cnt       <= '0;
      len_q     <= '0;
      rd_vld_p0 <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      done      <= 1'b0;
    end else begin
      state <= state_d;
      done  <= 1'b0;
      // capture stage: data on the bus now answers the command issued a cycle ago
      rd_vld_p0 <= (state == RD);
      rsp_valid <= rd_vld_p0;
      if (rd_vld_p0) rsp_data <= data;
      case (state)
        IDLE: begin
          if (req_valid) begin
            cmd_out  <= req_write;
            data_oe  <= req_write;
            addr_out <= req_addr;
            len_q    <= req_len;
            cnt      <= CNT_W'(1);
          end
        end
        WR: begin
          if (more) begin
            addr_out <= addr_out + ADDR_W'(1);
            cnt      <= cnt + CNT_W'(1);
          end else begin
            cmd_out <= 1'b0;
            data_oe <= 1'b0;
`ifdef DMAU_READBACK_EN
            addr_out <= start_addr;
            cnt      <= CNT_W'(1);
`else
            done <= 1'b1;
`endif
          end
        end
        RD: begin
          if (more) begin
            addr_out <= addr_out + ADDR_W'(1);
            cnt      <= cnt + CNT_W'(1);
          end
        end
        RD_TAIL: done <= 1'b1;
`ifdef DMAU_READBACK_EN
        VERIFY: begin
          if (more) begin
            addr_out <= addr_out + ADDR_W'(1);
            cnt      <= cnt + CNT_W'(1);
          end
        end
        VERIFY_TAIL: done <= 1'b1;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
- CPU-side initiator for the 8-bit data memory port. Drives cmd/addr, and drives the bidirectional data bus on writes.
- Turns single- or multi-beat load/store requests from the core into per-cycle memory commands. Consecutive addresses auto-increment.
- Returns read data as a pipelined per-beat response stream. Pulses done at the end of each request.

Parameters:
- ADDR_W, 8, memory address width.
- DATA_W, 8, data bus width.
- MAX_LEN_W, 3, width of the beat-count field; bursts are 1..2^MAX_LEN_W beats.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  request offered
- req_ready  out  1  unit can accept; high only in IDLE
- req_write  in  1  1 = store burst, 0 = load burst
- req_addr  in  ADDR_W  first beat address
- req_len  in  MAX_LEN_W  beats minus 1
- wr_data  in  DATA_W  store data for the current beat (show-ahead source)
- wr_pop  out  1  wr_data consumed this cycle
- cmd_out  out  1  memory command: 0 = read, 1 = write
- addr_out  out  ADDR_W  memory address
- data  inout  DATA_W  memory data bus
- rsp_valid  out  1  rsp_data valid this cycle; there is no backpressure
- rsp_data  out  DATA_W  captured read beat
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse when the request completes
- err  out  1  readback mismatch, sticky (optional feature only; otherwise tied 0)

Behaviour:
- Reset values (sync reset, effective at the rst edge):
  - state = IDLE.
  - cmd_out = 0, addr_out = 0, data_oe = 0 (data = Z).
  - rsp_valid = 0, rsp_data = 0, done = 0, err = 0, wr_pop = 0.
- Reset mid-operation aborts immediately: no further beats, no done, and the partial burst is left as-is in memory.
- All memory-side outputs (cmd_out, addr_out, data_oe, data drive value) are registered. The memory samples them at the following edge.
- data is driven only when data_oe = 1. Otherwise it is high-impedance and sampled as input.
- States: IDLE, WR, RD, RD_TAIL, plus VERIFY and VERIFY_TAIL when the optional feature is enabled.
- Bookkeeping:
  - Beat counter cnt (MAX_LEN_W+1 bits) counts issued beats.
  - Address register increments by 1 per issued beat and wraps modulo 2^ADDR_W (0xFF -> 0x00).
- IDLE:
  - cmd_out = 0 (non-destructive read), data_oe = 0, addr_out holds its last value.
  - Acceptance at edge E0 when req_valid && req_ready. At E0: cmd_out <= req_write, addr_out <= req_addr, cnt <= 1.
  - Write request: data_oe <= 1, data reg <= wr_data, wr_pop = 1 in the cycle before E0.
- WR:
  - One beat per cycle; the memory writes beat k at edge E(k+1).
  - While cnt < len+1 at each edge: address increments, the next wr_data is loaded, and wr_pop is high in the preceding cycle.
  - Last-beat edge: cmd_out <= 0, data_oe <= 0. Return to IDLE with done = 1 for the next cycle.
  - An N-beat write occupies N cycles after acceptance; wr_pop fires exactly N times.
- RD (pipelined):
  - Read commands issue one per cycle.
  - Memory data for the beat issued in cycle k is valid in cycle k+1 and is captured at the next edge.
  - rsp_valid is high in the cycle after capture.
  - After the last issue the unit enters RD_TAIL for one capture edge, then IDLE.
  - done coincides with the final rsp_valid.
  - For a 1-beat read: acceptance E0, memory samples E1, capture E2, rsp_valid/done in cycle E2–E3.
  - rsp_valid fires exactly N times, in consecutive cycles.
- req_ready is low from acceptance through the done cycle. A new request may be accepted at the edge ending the done cycle.
- req_valid while busy is ignored; the initiator must hold it.
- err clears on the next accepted request.

Optional Feature:
- Macro: DMAU_READBACK_EN.
- Enabled:
  - Store bursts keep each written byte in an internal 2^MAX_LEN_W x DATA_W buffer.
  - After the last write beat, the unit enters VERIFY: a pipelined read of the same address range (same wrap rules), then VERIFY_TAIL.
  - Each returned byte is compared with the buffered value. Any mismatch sets err.
  - rsp_valid stays 0 during verify.
  - done is delayed until the final compare: write latency N + (N + 1) cycles.
- Disabled: no buffer, no VERIFY states, err tied 0, write latency N cycles.

Test Plan:
- Reset mid write burst: req_write = 1, len = 7 at 0x10; assert rst after 3 beats -> next cycle cmd_out = 0, data = Z, busy = 0, no done; mem[0x10..0x12] written, mem[0x13] unchanged.
- Single write then single read: write 0xA5 to 0x04, then read 0x04 -> wr_pop 1x, cmd_out = 1 for exactly 1 cycle; rsp_data = 0xA5 with rsp_valid two edges after read acceptance, done with it.
- Wrapping 4-beat read from 0xFE, memory preloaded {0xFE:0x11, 0xFF:0x22, 0x00:0x33, 0x01:0x44} -> addr_out sequence FE, FF, 00, 01; rsp_data 11, 22, 33, 44 on consecutive cycles; done on the 4th.
- Back-to-back: hold req_valid high with a write len = 2 then a read len = 2 -> the second request is accepted at the edge ending the first done cycle; no data-bus drive during read cycles (data_oe = 0).
- DMAU_READBACK_EN: 2-beat write to 0x20 with the memory model forced to corrupt 0x21 -> err = 1 at done (cycle 5 after acceptance), stays 1 until the next acceptance, then clears.
